// File: rtl/enoc_sa_pkg.sv
// rtl/enoc_sa_pkg.sv - shared port indices, types and helpers for the switch allocator
package enoc_sa_pkg;

  localparam int NPORTS = 5;
  localparam int C_PORT = 0;
  localparam int N_PORT = 1;
  localparam int E_PORT = 2;
  localparam int S_PORT = 3;
  localparam int W_PORT = 4;

  typedef logic [0:4] port_vec_t;
  typedef logic [2:0] port_idx_t;

  function automatic port_idx_t next_port(input port_idx_t p);
    return (p == port_idx_t'(NPORTS - 1)) ? '0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/enoc_rr_lock_arbiter.sv
// rtl/enoc_rr_lock_arbiter.sv - 5-way round-robin arbiter with wormhole lock for one output
module enoc_rr_lock_arbiter
  import enoc_sa_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  port_vec_t req,
  input  port_vec_t tail,
  input  logic      out_en,
  output port_vec_t grant,
  output logic      locked,
  output port_idx_t owner
);

  port_idx_t ptr;
  port_idx_t win_idx;
  port_idx_t cand;
  logic      win;

  always_comb begin
    grant   = '0;
    win     = 1'b0;
    win_idx = owner;
    cand    = ptr;
    if (reset_n && out_en) begin
      if (locked) begin
        win = req[owner];
      end else begin
        for (int k = 0; k < NPORTS; k++) begin
          if (!win && req[cand]) begin
            win     = 1'b1;
            win_idx = cand;
          end
          cand = next_port(cand);
        end
      end
      if (win) grant[win_idx] = 1'b1;
    end
  end

  // Pointer only advances on head flits; body/tail flits keep it frozen.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      locked <= 1'b0;
      owner  <= '0;
      ptr    <= '0;
    end else if (win) begin
      if (!locked) begin
        ptr <= next_port(win_idx);
        if (!tail[win_idx]) begin
          locked <= 1'b1;
          owner  <= win_idx;
        end
      end else if (tail[win_idx]) begin
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/enoc_switch_allocator.sv
// rtl/enoc_switch_allocator.sv - per-router switch allocator; ENOC_SA_XFER_CNT_EN adds transfer counters
module enoc_switch_allocator
  import enoc_sa_pkg::*;
#(
  parameter int PORTS = 5
`ifdef ENOC_SA_XFER_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [0:4][0:4]        i_req,
  input  logic [0:4]             i_val,
  input  logic [0:4]             i_tail,
  input  logic [0:4]             i_out_en,
  output logic [0:4][0:4]        o_grant,
  output logic [0:4][0:4]        o_xbar_sel,
  output logic [0:4]             o_out_val
`ifdef ENOC_SA_XFER_CNT_EN
  , output logic [0:4][CNT_W-1:0] o_xfer_cnt
`endif
);

  logic [0:4][0:4] col_req;
  port_vec_t       col_grant [NPORTS];
  logic            lock      [NPORTS];
  port_idx_t       owner     [NPORTS];

  always_comb begin
    col_req = '0;
    for (int j = 0; j < NPORTS; j++)
      for (int i = 0; i < NPORTS; i++)
        col_req[j][i] = i_val[i] & i_req[i][j];
  end

  for (genvar j = 0; j < PORTS; j++) begin : g_out
    enoc_rr_lock_arbiter u_arb (
      .clk    (clk),
      .reset_n(reset_n),
      .req    (col_req[j]),
      .tail   (i_tail),
      .out_en (i_out_en[j]),
      .grant  (col_grant[j]),
      .locked (lock[j]),
      .owner  (owner[j])
    );
  end

  always_comb begin
    o_grant    = '0;
    o_xbar_sel = '0;
    o_out_val  = '0;
    for (int j = 0; j < NPORTS; j++) begin
      o_xbar_sel[j] = col_grant[j];
      o_out_val[j]  = |col_grant[j];
      for (int i = 0; i < NPORTS; i++)
        o_grant[i][j] = col_grant[j][i];
    end
  end

`ifdef ENOC_SA_XFER_CNT_EN
  always_ff @(posedge clk) begin
    for (int j = 0; j < NPORTS; j++) begin
      if (!reset_n)
        o_xfer_cnt[j] <= '0;
      else if (o_out_val[j] && (o_xfer_cnt[j] != '1))
        o_xfer_cnt[j] <= o_xfer_cnt[j] + 1'b1;
    end
  end
`endif

  // Flags stimulus whose outcome the allocator leaves undefined.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < NPORTS; i++)
        assert (!i_val[i] || $onehot0(i_req[i]))
          else $error("multi-hot request on input %0d", i);
      for (int j = 0; j < NPORTS; j++)
        if (lock[j] && i_val[owner[j]])
          assert (i_req[owner[j]][j])
            else $error("locked owner %0d left output %0d mid-packet", owner[j], j);
    end
  end

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// tb/tb_enoc_switch_allocator.sv - directed self-checking bench for enoc_switch_allocator
module tb_enoc_switch_allocator;
  import enoc_sa_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [0:4][0:4] i_req;
  logic [0:4]      i_val;
  logic [0:4]      i_tail;
  logic [0:4]      i_out_en;
  logic [0:4][0:4] o_grant;
  logic [0:4][0:4] o_xbar_sel;
  logic [0:4]      o_out_val;
`ifdef ENOC_SA_XFER_CNT_EN
  logic [0:4][3:0] o_xfer_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  enoc_switch_allocator #(
    .PORTS(5)
`ifdef ENOC_SA_XFER_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (i_req),
    .i_val     (i_val),
    .i_tail    (i_tail),
    .i_out_en  (i_out_en),
    .o_grant   (o_grant),
    .o_xbar_sel(o_xbar_sel),
    .o_out_val (o_out_val)
`ifdef ENOC_SA_XFER_CNT_EN
    , .o_xfer_cnt(o_xfer_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  function automatic logic [0:4][0:4] gb(input int i, input int j);
    logic [0:4][0:4] r;
    r = '0;
    r[i][j] = 1'b1;
    return r;
  endfunction

  // Checks grant matrix plus the output-valid and crossbar views derived from it.
  task automatic expg(input string tag, input logic [0:4][0:4] e);
    logic [0:4]      ov;
    logic [0:4][0:4] xs;
    ov = '0;
    xs = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        xs[j][i] = e[i][j];
        if (e[i][j]) ov[j] = 1'b1;
      end
    chk({tag, ".grant"}, 32'(o_grant), 32'(e));
    chk({tag, ".out_val"}, 32'(o_out_val), 32'(ov));
    chk({tag, ".xbar"}, 32'(o_xbar_sel), 32'(xs));
  endtask

  task automatic rq(input int i, input int j, input logic tl);
    i_val[i]  = 1'b1;
    i_req[i]  = '0;
    i_req[i][j] = 1'b1;
    i_tail[i] = tl;
  endtask

  task automatic drop(input int i);
    i_val[i]  = 1'b0;
    i_req[i]  = '0;
    i_tail[i] = 1'b0;
  endtask

  task automatic clr();
    i_req  = '0;
    i_val  = '0;
    i_tail = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq3 [4];
    seq3 = '{1, 3, 4, 1};
    reset_n  = 1'b0;
    clr();
    i_out_en = '1;
    rq(0, E_PORT, 1'b1);
    rq(3, W_PORT, 1'b0);
    cyc();
    cyc();
    #2;
    expg("reset", '0);
    cyc();

    // Single-flit request; next two cycles expose ptr[2]=1 and the unlocked state.
    reset_n = 1'b1;
    clr();
    rq(0, E_PORT, 1'b1);
    #2;
    expg("single", gb(0, 2));
    cyc();
    rq(1, E_PORT, 1'b1);
    #2;
    expg("single_ptr", gb(1, 2));
    cyc();
    #2;
    expg("single_wrap", gb(0, 2));
    cyc();
    clr();

    // Round-robin contention on west.
    rq(1, W_PORT, 1'b1);
    rq(3, W_PORT, 1'b1);
    rq(4, W_PORT, 1'b1);
    for (int c = 0; c < 4; c++) begin
      #2;
      expg($sformatf("rr%0d", c), gb(seq3[c], 4));
      cyc();
    end
    clr();

    // 4-flit wormhole packet on south blocks input 4 until after the tail.
    rq(2, S_PORT, 1'b0);
    rq(4, S_PORT, 1'b1);
    for (int f = 0; f < 4; f++) begin
      i_tail[2] = (f == 3);
      #2;
      expg($sformatf("worm%0d", f), gb(2, 3));
      cyc();
    end
    drop(2);
    #2;
    expg("worm_after", gb(4, 3));
    cyc();
    clr();

    // Owner bubble on north holds the lock.
    rq(0, N_PORT, 1'b0);
    rq(1, N_PORT, 1'b1);
    #2;
    expg("bub_head", gb(0, 1));
    cyc();
    i_val[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #2;
      expg($sformatf("bub%0d", c), '0);
      cyc();
    end
    i_val[0]  = 1'b1;
    i_tail[0] = 1'b1;
    #2;
    expg("bub_tail", gb(0, 1));
    cyc();
    drop(0);
    #2;
    expg("bub_next", gb(1, 1));
    cyc();
    clr();

    // Output disabled for 3 cycles, then a 2-flit packet from input 3 (ptr[2]=1).
    i_out_en[2] = 1'b0;
    rq(3, E_PORT, 1'b0);
    rq(0, E_PORT, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #2;
      expg($sformatf("oen%0d", c), '0);
      cyc();
    end
    i_out_en[2] = 1'b1;
    #2;
    expg("oen_head", gb(3, 2));
    cyc();
    i_tail[3] = 1'b1;
    #2;
    expg("oen_tail", gb(3, 2));
    cyc();
    drop(3);
    #2;
    expg("oen_next", gb(0, 2));
    cyc();
    clr();

    // Reset after 2 of 5 flits discards the lock.
    rq(1, W_PORT, 1'b0);
    for (int f = 0; f < 2; f++) begin
      #2;
      expg($sformatf("rst_pkt%0d", f), gb(1, 4));
      cyc();
    end
    rq(2, W_PORT, 1'b1);
    reset_n = 1'b0;
    #2;
    expg("rst_mid", '0);
    cyc();
    reset_n = 1'b1;
    drop(1);
    #2;
    expg("rst_after", gb(2, 4));
    cyc();
    clr();

    // All five outputs granted together.
    rq(0, E_PORT, 1'b1);
    rq(1, S_PORT, 1'b1);
    rq(2, W_PORT, 1'b1);
    rq(3, C_PORT, 1'b1);
    rq(4, N_PORT, 1'b1);
    #2;
    expg("all5", gb(0, 2) | gb(1, 3) | gb(2, 4) | gb(3, 0) | gb(4, 1));
    cyc();
    clr();

`ifdef ENOC_SA_XFER_CNT_EN
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    #2;
    chk("cnt_reset", 32'(o_xfer_cnt[1]), 32'd0);
    rq(0, N_PORT, 1'b1);
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (c == 4) chk("cnt_5", 32'(o_xfer_cnt[1]), 32'd5);
    end
    clr();
    #2;
    chk("cnt_sat", 32'(o_xfer_cnt[1]), 32'd15);
    chk("cnt_other", 32'(o_xfer_cnt[2]), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
